// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard-detection and forwarding controller for the 5-stage MIPS pipeline.
// The block keeps a shadow copy of the EX, MEM and WB destination and control
// state. From that state and the ID-stage decode it produces these outputs:
//   - load-use, branch-operand and MDU stalls (pc_stall / ifid_stall / idex_bubble)
//   - the taken-branch flush of IF/ID (ifid_flush)
//   - the 2-bit EX operand forwarding selects (fwd_a / fwd_b)
//   - the MDU busy flag and a saturating stall-cycle counter
//
// Parameters
//   REG_AW   register address width (register 0 reads as zero)
//   MDU_LAT  cycles the MDU stays busy after a mult/div issues
//   CNT_W    width of the MDU countdown
//   PERF_W   width of the stall performance counter
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt             ID source register addresses
//   id_uses_rs, id_uses_rt   ID instruction reads rs / rt
//   id_rd                    ID destination register (after RegDst mux)
//   id_reg_wre, id_mem_rd    ID writes a register / ID is a load
//   id_is_branch             ID compares registers (branch, jr, jalr)
//   id_redirect              ID resolved a taken branch or jump
//   id_is_mdu, id_reads_hilo ID is mult/div / ID is mfhi/mflo
//   pc_stall, ifid_stall     hold PC / hold IF/ID
//   ifid_flush               zero IF/ID at the next edge
//   idex_bubble              load a NOP into ID/EX at the next edge
//   fwd_a, fwd_b             00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   mdu_busy                 MDU countdown is non-zero
//   stall_count              saturating count of stalled cycles
//
// While rst is high, every output is forced to zero.

module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 3,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wre,
    input  logic              id_mem_rd,
    input  logic              id_is_branch,
    input  logic              id_redirect,
    input  logic              id_is_mdu,
    input  logic              id_reads_hilo,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LAT);

    // Shadow pipeline state
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_reg_wre;
    logic              ex_load;

    logic              mem_valid;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_reg_wre;
    logic              mem_load;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic              wb_reg_wre;

    logic [CNT_W-1:0]  mdu_count;
    logic [PERF_W-1:0] perf_count;

    logic              stall;
    logic              mdu_issue;

    // A stage "produces" a source register only when it really writes a
    // non-zero register with that address.
    function automatic logic dst_match(
        input logic              valid,
        input logic              wre,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] src
    );
        return valid & wre & (dst != '0) & (dst == src);
    endfunction

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, branch_haz, mdu_haz, busy_int;

    assign ex_hit_rs  = id_uses_rs & dst_match(ex_valid, ex_reg_wre, ex_dst, id_rs);
    assign ex_hit_rt  = id_uses_rt & dst_match(ex_valid, ex_reg_wre, ex_dst, id_rt);
    assign mem_hit_rs = id_uses_rs & dst_match(mem_valid, mem_reg_wre, mem_dst, id_rs);
    assign mem_hit_rt = id_uses_rt & dst_match(mem_valid, mem_reg_wre, mem_dst, id_rt);

    assign busy_int   = (mdu_count != '0);

    assign load_use   = (ex_hit_rs | ex_hit_rt) & ex_load;
    // Branches compare in ID, so they must wait for any EX result.
    // A load that is still in MEM also blocks the branch.
    assign branch_haz = id_is_branch &
                        ((ex_hit_rs | ex_hit_rt) | ((mem_hit_rs | mem_hit_rt) & mem_load));
    assign mdu_haz    = (id_is_mdu | id_reads_hilo) & busy_int;

    assign stall      = ~rst & id_valid & (load_use | branch_haz | mdu_haz);
    assign mdu_issue  = id_valid & id_is_mdu & ~stall;

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    // A stall takes priority over a redirect. The branch is decided again
    // once its operands are ready.
    assign ifid_flush  = ~rst & id_valid & id_redirect & ~stall;
    assign mdu_busy    = ~rst & busy_int;
    assign stall_count = rst ? '0 : perf_count;

    // EX operand selects. When both later stages write the same register,
    // the younger result in EX/MEM wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst && ex_valid) begin
            if (dst_match(mem_valid, mem_reg_wre, mem_dst, ex_rs))
                fwd_a = 2'b01;
            else if (dst_match(wb_valid, wb_reg_wre, wb_dst, ex_rs))
                fwd_a = 2'b10;

            if (dst_match(mem_valid, mem_reg_wre, mem_dst, ex_rt))
                fwd_b = 2'b01;
            else if (dst_match(wb_valid, wb_reg_wre, wb_dst, ex_rt))
                fwd_b = 2'b10;
        end
    end

    // The shadow pipeline advances EX->MEM->WB every edge. EX takes the ID
    // instruction, or a fully zeroed bubble when ID is stalled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dst      <= '0;
            ex_reg_wre  <= 1'b0;
            ex_load     <= 1'b0;
            mem_valid   <= 1'b0;
            mem_dst     <= '0;
            mem_reg_wre <= 1'b0;
            mem_load    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_dst      <= '0;
            wb_reg_wre  <= 1'b0;
        end else begin
            wb_valid    <= mem_valid;
            wb_dst      <= mem_dst;
            wb_reg_wre  <= mem_reg_wre;

            mem_valid   <= ex_valid;
            mem_dst     <= ex_dst;
            mem_reg_wre <= ex_reg_wre;
            mem_load    <= ex_load;

            if (id_valid && !stall) begin
                ex_valid   <= 1'b1;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_dst     <= id_rd;
                ex_reg_wre <= id_reg_wre;
                ex_load    <= id_mem_rd;
            end else begin
                ex_valid   <= 1'b0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_dst     <= '0;
                ex_reg_wre <= 1'b0;
                ex_load    <= 1'b0;
            end
        end
    end

    // MDU interlock countdown. An issue can never happen while the counter
    // is busy, because that issue is itself stalled.
    always_ff @(posedge clk) begin
        if (rst)
            mdu_count <= '0;
        else if (mdu_issue)
            mdu_count <= MDU_LOAD;
        else if (busy_int)
            mdu_count <= mdu_count - 1'b1;
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst)
            perf_count <= '0;
        else if (stall && (perf_count != '1))
            perf_count <= perf_count + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
// A reference model keeps the in-flight instructions as records in an array
// (EX, MEM, WB) and derives every output from the hazard and forwarding rules.
// A negedge process compares all outputs with that model on every cycle.
// Directed sequences pin the model with hand-computed values.

module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 3;
    localparam int PW  = 4;
    localparam int SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic          id_reg_wre, id_mem_rd;
    logic          id_is_branch, id_redirect;
    logic          id_is_mdu, id_reads_hilo;
    logic          pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          mdu_busy;
    logic [PW-1:0] stall_count;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW (AW),
        .MDU_LAT(LAT),
        .CNT_W  (CW),
        .PERF_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_wre   (id_reg_wre),
        .id_mem_rd    (id_mem_rd),
        .id_is_branch (id_is_branch),
        .id_redirect  (id_redirect),
        .id_is_mdu    (id_is_mdu),
        .id_reads_hilo(id_reads_hilo),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mdu_busy     (mdu_busy),
        .stall_count  (stall_count)
    );

    // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit v;
        int rs;
        int rt;
        int rd;
        bit wre;
        bit ld;
    } instr_t;

    localparam instr_t NOP = '{v: 1'b0, rs: 0, rt: 0, rd: 0, wre: 1'b0, ld: 1'b0};

    instr_t pipe [3];
    int     mdu_age;      // edges since the last mult/div issued
    int     model_stalls;

    function automatic bit writes(input instr_t p, input int r);
        return p.v && p.wre && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic bit dep_on(input instr_t p);
        return (id_uses_rs && writes(p, int'(id_rs))) ||
               (id_uses_rt && writes(p, int'(id_rt)));
    endfunction

    function automatic bit model_stall();
        bit need;
        if (!id_valid) return 1'b0;
        need = 1'b0;
        if (dep_on(pipe[0]) && pipe[0].ld) need = 1'b1;
        if (id_is_branch && (dep_on(pipe[0]) || (dep_on(pipe[1]) && pipe[1].ld))) need = 1'b1;
        if ((id_is_mdu || id_reads_hilo) && (mdu_age < LAT)) need = 1'b1;
        return need;
    endfunction

    function automatic int model_fwd(input int r);
        if (r == 0) return 0;
        if (writes(pipe[1], r)) return 1;
        if (writes(pipe[2], r)) return 2;
        return 0;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = NOP;
        mdu_age      = 1000;
        model_stalls = 0;
    end

    always @(posedge clk) begin
        bit s;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = NOP;
            mdu_age      = 1000;
            model_stalls = 0;
        end else begin
            s = model_stall();
            if (s && model_stalls < SAT) model_stalls++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (id_valid && !s)
                pipe[0] = '{v: 1'b1, rs: int'(id_rs), rt: int'(id_rt), rd: int'(id_rd),
                            wre: id_reg_wre, ld: id_mem_rd};
            else
                pipe[0] = NOP;
            if (id_valid && id_is_mdu && !s)
                mdu_age = 0;
            else if (mdu_age < 1000)
                mdu_age++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        bit s;
        s = rst ? 1'b0 : model_stall();
        checkOutput("pc_stall",    pc_stall,    s);
        checkOutput("ifid_stall",  ifid_stall,  s);
        checkOutput("idex_bubble", idex_bubble, s);
        checkOutput("ifid_flush",  ifid_flush,
                    (!rst && id_valid && id_redirect && !s) ? 1 : 0);
        checkOutput("fwd_a", fwd_a, rst ? 0 : model_fwd(pipe[0].rs));
        checkOutput("fwd_b", fwd_b, rst ? 0 : model_fwd(pipe[0].rt));
        checkOutput("mdu_busy", mdu_busy, (!rst && mdu_age < LAT) ? 1 : 0);
        checkOutput("stall_count", stall_count, rst ? 0 : model_stalls);
    end

    task automatic clearInputs();
        id_valid      = 1'b0;
        id_rs         = '0;
        id_rt         = '0;
        id_rd         = '0;
        id_uses_rs    = 1'b0;
        id_uses_rt    = 1'b0;
        id_reg_wre    = 1'b0;
        id_mem_rd     = 1'b0;
        id_is_branch  = 1'b0;
        id_redirect   = 1'b0;
        id_is_mdu     = 1'b0;
        id_reads_hilo = 1'b0;
    endtask

    task automatic applyStimulus(input bit v, input int rs, input int rt,
                                 input bit urs, input bit urt, input int rd,
                                 input bit wre, input bit ld, input bit br,
                                 input bit redir, input bit mdu, input bit hilo);
        @(posedge clk);
        #1;
        id_valid      = v;
        id_rs         = rs[AW-1:0];
        id_rt         = rt[AW-1:0];
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_rd         = rd[AW-1:0];
        id_reg_wre    = wre;
        id_mem_rd     = ld;
        id_is_branch  = br;
        id_redirect   = redir;
        id_is_mdu     = mdu;
        id_reads_hilo = hilo;
    endtask

    task automatic applyIdle();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clearInputs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall_count", stall_count, 0);
        checkOutput("reset_fwd_a", fwd_a, 0);
        checkOutput("reset_mdu_busy", mdu_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw $2 then add $3,$2,$4: one stall, then forward from MEM/WB
        applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lu_stall", pc_stall, 1);
        checkOutput("lu_bubble", idex_bubble, 1);
        @(negedge clk);
        checkOutput("lu_release", pc_stall, 0);
        applyIdle();
        @(negedge clk);
        checkOutput("lu_fwd_a", fwd_a, 2);
        checkOutput("lu_fwd_b", fwd_b, 0);

        // sub $5 reaches WB and add $5 reaches MEM; the EX reader takes EX/MEM
        applyStimulus(1, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0);
        applyIdle();
        @(negedge clk);
        checkOutput("fwd_mem_wins", fwd_a, 1);
        // The same sequence targeting $0 never forwards
        applyStimulus(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0);
        applyIdle();
        @(negedge clk);
        checkOutput("fwd_reg0", fwd_a, 0);

        // beq $6 behind lw $6: two stall cycles, then a single flush
        applyStimulus(1, 1, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 6, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("br_stall1", pc_stall, 1);
        checkOutput("br_noflush1", ifid_flush, 0);
        @(negedge clk);
        checkOutput("br_stall2", pc_stall, 1);
        checkOutput("br_noflush2", ifid_flush, 0);
        @(negedge clk);
        checkOutput("br_go", pc_stall, 0);
        checkOutput("br_flush", ifid_flush, 1);
        applyIdle();
        @(negedge clk);
        checkOutput("br_flush_once", ifid_flush, 0);

        // mult, then mflo waits four cycles
        pulseReset();
        applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("mdu_stall", pc_stall, 1);
            checkOutput("mdu_busy_on", mdu_busy, 1);
        end
        @(negedge clk);
        checkOutput("mdu_issue", pc_stall, 0);
        checkOutput("mdu_busy_off", mdu_busy, 0);
        checkOutput("mdu_stall_count", stall_count, 4);
        applyIdle();

        // Reset while the countdown sits at 2 leaves nothing behind
        pulseReset();
        applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_busy", mdu_busy, 0);
        checkOutput("rst_mid_stall", pc_stall, 0);
        checkOutput("rst_mid_count", stall_count, 0);

        // Twenty stall cycles saturate a 4-bit counter
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
            applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1);
            repeat (4) @(posedge clk);
        end
        applyIdle();
        @(negedge clk);
        checkOutput("stall_saturate", stall_count, SAT);

        // Randomised traffic with a small register window to provoke hazards
        pulseReset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst           = ($urandom_range(0, 99) == 0);
            id_valid      = ($urandom_range(0, 9) != 0);
            id_rs         = AW'($urandom_range(0, 3));
            id_rt         = AW'($urandom_range(0, 3));
            id_rd         = AW'($urandom_range(0, 3));
            id_uses_rs    = ($urandom_range(0, 3) != 0);
            id_uses_rt    = ($urandom_range(0, 1) != 0);
            id_reg_wre    = ($urandom_range(0, 3) != 0);
            id_mem_rd     = ($urandom_range(0, 2) == 0);
            id_is_branch  = ($urandom_range(0, 3) == 0);
            id_redirect   = ($urandom_range(0, 3) == 0);
            id_is_mdu     = ($urandom_range(0, 14) == 0);
            id_reads_hilo = ($urandom_range(0, 7) == 0);
        end
        applyIdle();
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
